parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//  Controls the single shared barrier of the car park lane, which serves both entry
//  and exit traffic. Arbitrates between entry and exit requests and sequences the
//  barrier through open -> vehicle-pass -> close. Keeps the occupancy count and the
//  full flag. Sits between the lane request buttons/loops and the barrier actuator.
// PARAMETERS
//  CAPACITY        10    number of parking slots; must be < 2**CNT_W
//  CNT_W           8     width of the occupancy count
//  OPEN_CYCLES     4     minimum cycles the barrier stays open per service (>=1)
//  TIMEOUT_CYCLES  1000  cycles allowed in an OPEN state with no vehicle detected
//  TMR_W           16    timer width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous reset, active low
//  entry_req    in   1      vehicle waiting at entry; held until granted
//  exit_req     in   1      vehicle waiting at exit; held until granted
//  pass_sensor  in   1      1 = vehicle under the barrier
//  gate_open    out  1      barrier raise command
//  entry_grant  out  1      high while an entry is being serviced
//  exit_grant   out  1      high while an exit is being serviced
//  entry_deny   out  1      entry refused because the car park is full
//  count        out  CNT_W  current occupancy
//  full         out  1      count == CAPACITY
//  timeout_err  out  1      one-cycle pulse: barrier opened, no vehicle arrived
// BEHAVIOUR
//  - All outputs and state are registered. Async reset: state IDLE, timer 0,
//    last_served=EXIT, all outputs 0.
//  - States IDLE, OPEN_IN, PASS_IN, OPEN_OUT, PASS_OUT. Moore decode:
//    gate_open = any OPEN/PASS state; entry_grant = OPEN_IN|PASS_IN;
//    exit_grant = OPEN_OUT|PASS_OUT.
//  - IDLE, at each edge:
//    entry_ok = entry_req & ~full; exit_ok = exit_req & (count != 0).
//    Both ok: grant the direction that is not last_served. One ok: grant it.
//    Grant -> OPEN_IN/OPEN_OUT, timer <= 0. Latency: request sampled at edge N,
//    gate_open high after edge N.
//    entry_deny <= entry_req & full & ~exit_ok (registered; 0 in all other states).
//    exit_req while count==0 is ignored (no grant, no flag).
//  - Requests are ignored outside IDLE; requesters keep them held.
//  - The timer counts up every cycle in the OPEN and PASS states and saturates.
//  - OPEN_x: pass_sensor=1 -> PASS_x. Otherwise, if timer==TIMEOUT_CYCLES-1 ->
//    timeout_err pulse, IDLE, last_served <= x, count unchanged.
//  - PASS_x: leave only when pass_sensor==0 and timer >= OPEN_CYCLES -> IDLE,
//    last_served <= x. Entry: count+1. Exit: count-1. There is no timeout in PASS_x:
//    the barrier never closes onto a vehicle.
//  - full is registered with count. count never exceeds CAPACITY and never
//    underflows, because it is updated only from a granted service.
//  - Reset mid-service: the barrier closes at once and count returns to 0.
// TESTING
//  1 reset_n=0 during PASS_IN -> gate_open=0, count=0, full=0, state IDLE
//    immediately, with no clock edge needed.
//  2 entry_req=1, sensor 1 for 3 cycles, then 0 -> entry_grant and gate_open high
//    1 cycle after the request; gate_open held until timer>=4 with sensor clear;
//    then count 0->1.
//  3 entry_req and exit_req both held, count=5, after reset -> entry served first,
//    then exit; count ends at 5; service order alternates IN, OUT, IN, OUT.
//  4 count=10 (full=1), entry_req only -> entry_deny=1 and no gate_open.
//    Then a completed exit -> count=9, full=0, and the held entry is granted.
//  5 entry_req, pass_sensor never asserted -> timeout_err pulses exactly 1000
//    cycles after OPEN_IN is entered; gate_open drops; count unchanged.
//  6 exit_req with count=0 -> no grant and no deny. Sensor held high for 2000
//    cycles in PASS_OUT -> no timeout and the barrier stays open.

Source files
------------

// File: rtl/parking_gate_arbiter_if.sv
// Lane-side bundle for the car-park barrier arbiter: requests and the pass loop in, barrier/grant/status out.
// Latency: none (wires only); the arbiter registers every output.
// Backpressure: requesters hold entry_req/exit_req until the matching grant is seen.
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             entry_req;
  logic             exit_req;
  logic             pass_sensor;
  logic             gate_open;
  logic             entry_grant;
  logic             exit_grant;
  logic             entry_deny;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             timeout_err;

  // master: the lane (buttons, loops, supervisor); slave: the arbiter
  modport master (
    output entry_req, exit_req, pass_sensor,
    input  gate_open, entry_grant, exit_grant, entry_deny, count, full, timeout_err
  );
  modport slave (
    input  entry_req, exit_req, pass_sensor,
    output gate_open, entry_grant, exit_grant, entry_deny, count, full, timeout_err
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier arbiter with occupancy count, full flag and no-show timeout.
// Latency: request sampled at edge N -> gate_open/grant high after edge N; all outputs registered.
// Backpressure: requests are only looked at in IDLE; a full park denies entry, an empty park ignores exit.
// Ports: clk, reset_n (async, active low), bus (slave modport: entry_req, exit_req, pass_sensor in;
//        gate_open, entry_grant, exit_grant, entry_deny, count, full, timeout_err out).
module parking_gate_arbiter #(
  parameter int CAPACITY       = 10,
  parameter int CNT_W          = 8,
  parameter int OPEN_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  parking_gate_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN_IN  = 3'd1,
    PASS_IN  = 3'd2,
    OPEN_OUT = 3'd3,
    PASS_OUT = 3'd4
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             last_exit;   // 1 = the most recent service was an exit

  logic             entry_ok;
  logic             exit_ok;
  logic [TMR_W-1:0] timer_inc;

  assign entry_ok  = bus.entry_req & ~bus.full;
  assign exit_ok   = bus.exit_req & (bus.count != '0);
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      timer           <= '0;
      last_exit       <= 1'b1;
      bus.gate_open   <= 1'b0;
      bus.entry_grant <= 1'b0;
      bus.exit_grant  <= 1'b0;
      bus.entry_deny  <= 1'b0;
      bus.count       <= '0;
      bus.full        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      bus.entry_deny  <= 1'b0;
      case (state)
        IDLE: begin
          // A deny is only raised when the barrier is not about to serve an exit instead.
          bus.entry_deny <= bus.entry_req & bus.full & ~exit_ok;
          // On contention the direction not served last wins.
          if (entry_ok && (!exit_ok || last_exit)) begin
            state           <= OPEN_IN;
            timer           <= '0;
            bus.gate_open   <= 1'b1;
            bus.entry_grant <= 1'b1;
          end else if (exit_ok) begin
            state          <= OPEN_OUT;
            timer          <= '0;
            bus.gate_open  <= 1'b1;
            bus.exit_grant <= 1'b1;
          end
        end
        OPEN_IN, OPEN_OUT: begin
          timer <= timer_inc;
          if (bus.pass_sensor) begin
            state <= (state == OPEN_IN) ? PASS_IN : PASS_OUT;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // Nobody turned up: close and let the other direction have a go.
            bus.timeout_err <= 1'b1;
            last_exit       <= (state == OPEN_OUT);
            state           <= IDLE;
            bus.gate_open   <= 1'b0;
            bus.entry_grant <= 1'b0;
            bus.exit_grant  <= 1'b0;
          end
        end
        PASS_IN, PASS_OUT: begin
          timer <= timer_inc;
          // No timeout here: the barrier must never come down on a vehicle.
          if (!bus.pass_sensor && (timer >= TMR_W'(OPEN_CYCLES))) begin
            last_exit       <= (state == PASS_OUT);
            state           <= IDLE;
            bus.gate_open   <= 1'b0;
            bus.entry_grant <= 1'b0;
            bus.exit_grant  <= 1'b0;
            if (state == PASS_IN) begin
              bus.count <= bus.count + 1'b1;
              bus.full  <= (bus.count == CNT_W'(CAPACITY - 1));
            end else begin
              bus.count <= bus.count - 1'b1;
              bus.full  <= 1'b0;
            end
          end
        end
        default: begin
          state           <= IDLE;
          bus.gate_open   <= 1'b0;
          bus.entry_grant <= 1'b0;
          bus.exit_grant  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios plus random traffic against a service-level model.
// Latency: model advances once per rising edge; outputs compared on the falling edge.
// Backpressure: bench requesters hold their request until the model shows the grant.
module tb_parking_gate_arbiter;

  localparam int CAP     = 10;
  localparam int OPEN_C  = 4;
  localparam int TOUT_C  = 1000;

  logic clk;
  logic reset_n;

  parking_gate_arbiter_if #(.CNT_W(8)) bus ();

  parking_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(8), .OPEN_CYCLES(OPEN_C),
    .TIMEOUT_CYCLES(TOUT_C), .TMR_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Service-level reference: which direction holds the barrier, whether the car has
  // shown up, how many edges since the barrier rose, and the park occupancy.
  int m_dir;        // 0 none, 1 entry, 2 exit
  bit m_car;
  int m_age;
  int m_count;
  bit m_last_exit;
  bit m_deny;
  bit m_tout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_car = 0; m_age = 0; m_count = 0;
    m_last_exit = 1; m_deny = 0; m_tout = 0;
  endtask

  task automatic model_step();
    bit eok, xok;
    m_tout = 0;
    m_deny = 0;
    if (m_dir == 0) begin
      eok    = bus.entry_req && (m_count < CAP);
      xok    = bus.exit_req && (m_count > 0);
      m_deny = bus.entry_req && (m_count == CAP) && !xok;
      if (eok && xok)  m_dir = m_last_exit ? 1 : 2;
      else if (eok)    m_dir = 1;
      else if (xok)    m_dir = 2;
      m_age = 0;
      m_car = 0;
    end else if (!m_car) begin
      if (bus.pass_sensor) begin
        m_car = 1;
        m_age++;
      end else if (m_age == TOUT_C - 1) begin
        m_tout      = 1;
        m_last_exit = (m_dir == 2);
        m_dir       = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (!bus.pass_sensor && m_age >= OPEN_C) begin
        m_count     = (m_dir == 1) ? m_count + 1 : m_count - 1;
        m_last_exit = (m_dir == 2);
        m_dir       = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_all();
    chk("gate_open",   bus.gate_open,   32'(m_dir != 0));
    chk("entry_grant", bus.entry_grant, 32'(m_dir == 1));
    chk("exit_grant",  bus.exit_grant,  32'(m_dir == 2));
    chk("entry_deny",  bus.entry_deny,  32'(m_deny));
    chk("count",       bus.count,       32'(m_count));
    chk("full",        bus.full,        32'(m_count == CAP));
    chk("timeout_err", bus.timeout_err, 32'(m_tout));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_gate(input logic want, input int limit, input string tag);
    int n;
    n = 0;
    while (bus.gate_open !== want && n < limit) begin
      tick();
      n++;
    end
    chk(tag, bus.gate_open, want);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.entry_req = 0; bus.exit_req = 0; bus.pass_sensor = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One full service: request, grant, car under the barrier for car_len cycles, close.
  task automatic service(input bit is_entry, input int car_len);
    if (is_entry) bus.entry_req = 1; else bus.exit_req = 1;
    wait_gate(1'b1, 20, "svc_open");
    chk(is_entry ? "svc_entry_grant" : "svc_exit_grant",
        is_entry ? bus.entry_grant : bus.exit_grant, 1);
    if (is_entry) bus.entry_req = 0; else bus.exit_req = 0;
    bus.pass_sensor = 1;
    repeat (car_len) tick();
    bus.pass_sensor = 0;
    wait_gate(1'b0, 20, "svc_close");
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    bus.entry_req = 0; bus.exit_req = 0; bus.pass_sensor = 0;
    model_reset();
    #3;
    check_all();
    apply_reset();

    // Exit request with an empty park: no grant, no deny.
    bus.exit_req = 1;
    repeat (5) tick();
    chk("empty_exit_gate", bus.gate_open, 0);
    chk("empty_exit_deny", bus.entry_deny, 0);
    bus.exit_req = 0;

    // Single entry: gate up one edge after the request, down once open >= 4 cycles and clear.
    bus.entry_req = 1;
    tick();
    chk("entry_latency_gate", bus.gate_open, 1);
    chk("entry_latency_grant", bus.entry_grant, 1);
    bus.entry_req = 0;
    bus.pass_sensor = 1;
    repeat (3) tick();
    bus.pass_sensor = 0;
    tick();
    chk("entry_hold_min_open", bus.gate_open, 1);
    tick();
    chk("entry_closed", bus.gate_open, 0);
    chk("entry_count_1", bus.count, 1);

    // Exit with the car parked under the barrier for 2000 cycles: no timeout, stays open.
    bus.exit_req = 1;
    wait_gate(1'b1, 20, "long_exit_open");
    bus.exit_req = 0;
    bus.pass_sensor = 1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.gate_open !== 1'b1 || bus.timeout_err !== 1'b0) n++;
    end
    chk("long_pass_stays_open", n, 0);
    bus.pass_sensor = 0;
    wait_gate(1'b0, 20, "long_exit_close");
    chk("long_exit_count", bus.count, 0);

    // Fill to 5, then both directions held: service must alternate, starting with exit.
    repeat (5) service(1'b1, 2);
    bus.entry_req = 1;
    bus.exit_req  = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gate(1'b1, 20, "alt_open");
      chk("alt_order_is_exit", bus.exit_grant, (k % 2 == 0) ? 1 : 0);
      bus.pass_sensor = 1;
      repeat (2) tick();
      bus.pass_sensor = 0;
      wait_gate(1'b0, 20, "alt_close");
    end
    bus.entry_req = 0;
    bus.exit_req  = 0;
    tick();
    chk("alt_count_5", bus.count, 5);

    // Fill to capacity: entry denied, then an exit frees a slot for the held entry.
    repeat (5) service(1'b1, 1);
    chk("full_flag", bus.full, 1);
    bus.entry_req = 1;
    repeat (3) tick();
    chk("full_deny", bus.entry_deny, 1);
    chk("full_no_gate", bus.gate_open, 0);
    bus.exit_req = 1;
    wait_gate(1'b1, 20, "full_exit_open");
    chk("full_exit_grant", bus.exit_grant, 1);
    bus.exit_req = 0;
    bus.pass_sensor = 1;
    repeat (2) tick();
    bus.pass_sensor = 0;
    wait_gate(1'b0, 20, "full_exit_close");
    chk("after_exit_count", bus.count, 9);
    chk("after_exit_full", bus.full, 0);
    wait_gate(1'b1, 20, "held_entry_open");
    chk("held_entry_grant", bus.entry_grant, 1);
    bus.entry_req = 0;
    bus.pass_sensor = 1;
    tick();
    bus.pass_sensor = 0;
    wait_gate(1'b0, 20, "held_entry_close");
    service(1'b0, 1);

    // No-show at the entry: timeout pulse exactly 1000 cycles after the barrier rose.
    bus.entry_req = 1;
    wait_gate(1'b1, 20, "tout_open");
    bus.entry_req = 0;
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, TOUT_C);
    chk("timeout_gate_down", bus.gate_open, 0);
    chk("timeout_count", bus.count, 9);
    tick();
    chk("timeout_one_cycle", bus.timeout_err, 0);

    // Random traffic: requests held until granted, random car dwell times.
    for (int i = 0; i < 3000; i++) begin
      if (m_dir == 1) bus.entry_req = 0;
      if (m_dir == 2) bus.exit_req = 0;
      if (m_dir == 0) begin
        if (!bus.entry_req && $urandom_range(0, 3) == 0) bus.entry_req = 1;
        if (!bus.exit_req && $urandom_range(0, 3) == 0) bus.exit_req = 1;
        if (bus.exit_req && m_count == 0 && $urandom_range(0, 7) == 0) bus.exit_req = 0;
        bus.pass_sensor = 0;
      end else begin
        bus.pass_sensor = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    bus.entry_req = 0;
    bus.exit_req  = 0;
    bus.pass_sensor = 0;
    repeat (30) tick();

    // Reset while a car is under the entry barrier: closes without any clock edge.
    if (m_count == CAP) service(1'b0, 1);
    service(1'b1, 1);
    bus.entry_req = 1;
    wait_gate(1'b1, 20, "rst_open");
    bus.entry_req = 0;
    bus.pass_sensor = 1;
    repeat (2) tick();
    chk("rst_pre_count_nonzero", 32'(bus.count != 0), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_gate", bus.gate_open, 0);
    chk("rst_grant", bus.entry_grant, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    model_reset();
    bus.pass_sensor = 0;
    @(negedge clk);
    reset_n = 1'b1;
    service(1'b1, 1);
    chk("rst_idle_then_entry", bus.count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
